// File: rtl/display_scanner_pkg.sv
// Shared constants and helpers for the multiplexed 4-digit 7-segment scanner.
package display_scanner_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int VAL_W      = NUM_DIGITS * DIGIT_W;
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

  typedef logic [1:0] slot_t;

  typedef struct packed {
    logic [DIGIT_W-1:0]    digit;
    logic [NUM_DIGITS-1:0] anode;
    logic                  frame_start;
  } scan_out_t;

  // A slot is a leading zero when it and every more-significant digit are 0;
  // slot 0 is never a leading zero so an all-zero value still shows "0".
  function automatic logic lz_blank(input logic [VAL_W-1:0] val, input slot_t slot);
    logic z;
    z = (slot != 2'd0);
    for (int n = 0; n < NUM_DIGITS; n++) begin
      if (n >= int'(slot) && val[n*DIGIT_W +: DIGIT_W] != '0) z = 1'b0;
    end
    return z;
  endfunction

endpackage

// File: rtl/display_scanner_prescaler.sv
// Slot-rate prescaler: counts 0..REFRESH_DIV-1 and flags the wrap cycle as tick.
module scan_prescaler #(
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = $clog2(REFRESH_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             tick,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick  = (cnt_q == LAST);
  assign count = cnt_q;

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/display_scanner.sv
// Four-digit multiplexed display scanner with double-buffered value,
// guard-band ghost suppression and optional leading-zero blanking.
module display_scanner
  import display_scanner_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value_in,
  input  logic        blank_lz,
  output logic [3:0]  digit,
  output logic [3:0]  anode,
  output logic        frame_start
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD);

  logic             tick;
  logic [CNT_W-1:0] cnt;
  logic             wrap;

  slot_t            idx_q, idx_d;
  logic [VAL_W-1:0] shown_q, shown_d;
  logic [VAL_W-1:0] pending_q, pending_d;
  logic             pend_vld_q, pend_vld_d;
  logic             blank_q, blank_d;
  scan_out_t        out_q, out_d;

  scan_prescaler #(
    .REFRESH_DIV (REFRESH_DIV),
    .CNT_W       (CNT_W)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .count (cnt)
  );

  assign wrap = tick && (idx_q == 2'd3);

  always_comb begin
    idx_d      = tick ? idx_q + 2'd1 : idx_q;
    shown_d    = shown_q;
    pending_d  = pending_q;
    pend_vld_d = pend_vld_q;
    blank_d    = tick ? blank_lz : blank_q;

    if (wrap) begin
      if (pend_vld_q) shown_d = pending_q;
      pend_vld_d = 1'b0;
    end
    // A load on the wrap tick lands after the copy, so it waits a full frame.
    if (load) begin
      pending_d  = value_in;
      pend_vld_d = 1'b1;
    end

    out_d.digit = shown_q[{idx_q, 2'b00} +: DIGIT_W];
    out_d.anode = ANODE_OFF;
    if (cnt >= GUARD_C && !(blank_q && lz_blank(shown_q, idx_q)))
      out_d.anode = ~(4'b0001 << idx_q);
    // First cycle of slot 0 lines up with the first registered slot-0 digit.
    out_d.frame_start = (idx_q == 2'd0) && (cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= 2'd0;
      shown_q    <= '0;
      pending_q  <= '0;
      pend_vld_q <= 1'b0;
      blank_q    <= 1'b0;
      out_q      <= '{digit: '0, anode: ANODE_OFF, frame_start: 1'b0};
    end else begin
      idx_q      <= idx_d;
      shown_q    <= shown_d;
      pending_q  <= pending_d;
      pend_vld_q <= pend_vld_d;
      blank_q    <= blank_d;
      out_q      <= out_d;
    end
  end

  assign digit       = out_q.digit;
  assign anode       = out_q.anode;
  assign frame_start = out_q.frame_start;

endmodule

// File: tb/tb_display_scanner.sv
// Scoreboarded bench for display_scanner at REFRESH_DIV=8, GUARD=2: the driver
// queues the expected outputs for every cycle, a monitor pops and compares.
module tb_display_scanner;

  localparam int DIV   = 8;
  localparam int GRD   = 2;
  localparam int FRAME = 4 * DIV;

  logic        clk;
  logic        rst, load, blank_lz;
  logic [15:0] value_in;
  logic [3:0]  digit, anode;
  logic        frame_start;

  display_scanner #(.REFRESH_DIV(DIV), .GUARD(GRD)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .value_in    (value_in),
    .blank_lz    (blank_lz),
    .digit       (digit),
    .anode       (anode),
    .frame_start (frame_start)
  );

  typedef struct packed {
    logic [3:0]  digit;
    logic [3:0]  anode;
    logic        fs;
    logic [15:0] e;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;

  // e counts rising edges since reset released; vis is the value that must be
  // on the display and beff the blanking mode in force, both set by hand below.
  int          e     = 0;
  logic [15:0] vis   = 16'h0;
  logic        beff  = 1'b0;
  logic        bz_in = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t expect_now();
    int   pos, slot;
    logic blank;
    exp_t x;
    pos  = (e - 1) % DIV;
    slot = ((e - 1) / DIV) % 4;
    x.digit = vis[slot*4 +: 4];
    blank = 1'b0;
    if (beff && slot != 0) begin
      blank = 1'b1;
      for (int n = slot; n < 4; n++) if (vis[n*4 +: 4] != 4'h0) blank = 1'b0;
    end
    x.anode = (pos < GRD || blank) ? 4'hF : ~(4'b0001 << slot);
    x.fs    = ((e - 1) % FRAME) == 0;
    x.e     = e[15:0];
    return x;
  endfunction

  task automatic cyc(input logic r, input logic ld, input logic [15:0] v);
    exp_t x;
    rst = r; load = ld; value_in = v; blank_lz = bz_in;
    @(posedge clk);
    #1;
    load = 1'b0;
    if (r) begin
      e = 0; vis = 16'h0; beff = 1'b0;
      x.digit = 4'h0; x.anode = 4'hF; x.fs = 1'b0; x.e = 16'h0;
      q.push_back(x);
    end else begin
      e++;
      q.push_back(expect_now());
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0);
  endtask

  task automatic run_to_wrap();
    while (e % FRAME != 0) cyc(1'b0, 1'b0, 16'h0);
  endtask

  function automatic void chk(input string nm, input logic [3:0] act,
                              input logic [3:0] exp, input logic [15:0] ec);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got %b expected %b", nm, ec, act, exp);
    end
  endfunction

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("digit", digit, x.digit, x.e);
        chk("anode", anode, x.anode, x.e);
        chk("frame_start", {3'b000, frame_start}, {3'b000, x.fs}, x.e);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    // Reset, with a load during reset that must be discarded.
    cyc(1'b1, 1'b0, 16'h0);
    cyc(1'b1, 1'b1, 16'hEEEE);

    // Basic scan: 0000 for the first frame, then 1234.
    cyc(1'b0, 1'b1, 16'h1234);
    run_to_wrap();
    vis = 16'h1234;
    run(FRAME);

    // Double buffer: last of two mid-frame loads wins at the wrap.
    run(10);
    cyc(1'b0, 1'b1, 16'h5678);
    cyc(1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b1, 16'h9999);
    run_to_wrap();
    vis = 16'h9999;
    run(FRAME);

    // Load on the wrap tick itself: old value holds one more frame.
    run(FRAME - 1);
    cyc(1'b0, 1'b1, 16'hABCD);
    run(FRAME);
    vis = 16'hABCD;
    run(FRAME);

    // Leading-zero blanking on 0042, then 0000.
    bz_in = 1'b1;
    beff  = 1'b1;
    cyc(1'b0, 1'b1, 16'h0042);
    run_to_wrap();
    vis = 16'h0042;
    run(FRAME);
    cyc(1'b0, 1'b1, 16'h0000);
    run_to_wrap();
    vis = 16'h0000;
    run(FRAME);

    // Dropping blank_lz mid-slot 1 only takes effect from slot 2.
    run(10);
    bz_in = 1'b0;
    run(6);
    beff = 1'b0;
    run_to_wrap();

    // Reset in slot 2 with a pending value: pending is lost.
    cyc(1'b0, 1'b1, 16'h7777);
    run(17);
    cyc(1'b1, 1'b0, 16'h0);
    cyc(1'b1, 1'b0, 16'h0);
    run(2 * FRAME);

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expected entries left, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
